control_sequencer: RTL and testbench

Multi-cycle hardwired control unit for the 32-bit bus datapath. It fetches instructions through PC/MAR/MDR/IR and decodes the IR opcode. It then drives, one step per clock, the one-hot register strobes, bus-source selects, ALU operation and memory read/write that execute each instruction. It sits beside the datapath and replaces the testbench-driven control inputs. Every datapath control pin is sourced from this block.

---
 rtl/control_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired multi-cycle control unit for the 32-bit bus datapath
// Moore decode of state and IR drives every datapath strobe; memory steps stall on mem_ready.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        PCout,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        Cout,
  output logic [7:0]  ALU_control,
  output logic        read,
  output logic        write,
  output logic        done,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  state
);

  localparam logic [7:0] INC_CODE = 8'h20;
  localparam logic [7:0] ADD_CODE = 8'h03;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   t1_wait_q, t1_wait_d;
  logic   step_done;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_rtype, is_addi, is_muldiv, is_ld, is_st, is_nop, is_halt;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_rtype  = (op >= 5'b00011) && (op <= 5'b01000);
  assign is_addi   = (op == 5'b01001);
  assign is_muldiv = (op == 5'b01111) || (op == 5'b10000);
  assign is_ld     = (op == 5'b00000);
  assign is_st     = (op == 5'b00010);
  assign is_nop    = (op == 5'b11000);
  assign is_halt   = (op == 5'b11111);

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'h0001 << idx;
  endfunction

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      t1_wait_q <= t1_wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    t1_wait_d   = 1'b0;
    step_done   = 1'b0;
    Rin         = 16'h0000;
    Rout        = 16'h0000;
    PCin        = 1'b0;
    PCout       = 1'b0;
    IRin        = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    Zlowout     = 1'b0;
    Zhighout    = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    Cout        = 1'b0;
    ALU_control = 8'h00;
    read        = 1'b0;
    write       = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        PCout       = 1'b1;
        MARin       = 1'b1;
        Zin         = 1'b1;
        ALU_control = INC_CODE;
        state_d     = S_T1;
      end
      S_T1: begin
        // PC is loaded once; the incremented value stays on the bus while the fetch stalls
        Zlowout = 1'b1;
        PCin    = !t1_wait_q;
        read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) state_d = S_T2;
        else           t1_wait_d = 1'b1;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_rtype || is_addi || is_ld || is_st) begin
          Rout    = onehot(rb);
          Yin     = 1'b1;
          state_d = S_T4;
        end else if (is_muldiv) begin
          Rout    = onehot(ra);
          Yin     = 1'b1;
          state_d = S_T4;
        end else if (is_nop) begin
          step_done = 1'b1;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_T4: begin
        Zin     = 1'b1;
        state_d = S_T5;
        if (is_rtype) begin
          Rout        = onehot(rc);
          ALU_control = {3'b000, op};
        end else if (is_muldiv) begin
          Rout        = onehot(rb);
          ALU_control = {3'b000, op};
        end else begin
          Cout        = 1'b1;
          ALU_control = ADD_CODE;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        state_d = S_T6;
        if (is_rtype || is_addi) begin
          Rin       = onehot(ra);
          step_done = 1'b1;
        end else if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          MARin = 1'b1;
        end
      end
      S_T6: begin
        if (is_muldiv) begin
          Zhighout  = 1'b1;
          HIin      = 1'b1;
          step_done = 1'b1;
        end else if (is_st) begin
          Rout    = onehot(ra);
          MDRin   = 1'b1;
          state_d = S_T7;
        end else begin
          read  = 1'b1;
          MDRin = 1'b1;
          if (mem_ready) state_d = S_T7;
        end
      end
      S_T7: begin
        if (is_st) begin
          write     = 1'b1;
          step_done = mem_ready;
        end else begin
          MDRout    = 1'b1;
          Rin       = onehot(ra);
          step_done = 1'b1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (step_done) state_d = run ? S_T0 : S_IDLE;
  end

  assign done    = step_done;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
// Expected per-cycle output snapshots are queued per instruction and popped each cycle.
module tb_control_sequencer;

  logic        clock, clear, run, mem_ready;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic        PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, Zin;
  logic        Zlowout, Zhighout, HIin, LOin, Cout;
  logic [7:0]  ALU_control;
  logic        read, write, done, halted, illegal;
  logic [3:0]  state;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcin, pcout, irin, marin, mdrin, mdrout, yin, zin, zlo, zhi, hiin, loin, cout;
    logic [7:0]  alu;
    logic rd, wr, dn, hl, il;
  } out_t;

  out_t dut_o;
  out_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Cout(Cout),
    .ALU_control(ALU_control), .read(read), .write(write), .done(done),
    .halted(halted), .illegal(illegal), .state(state)
  );

  assign dut_o = {state, Rin, Rout, PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, Zin,
                  Zlowout, Zhighout, HIin, LOin, Cout, ALU_control, read, write, done,
                  halted, illegal};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic out_t o(input logic [3:0] s);
    out_t r;
    r = '0;
    r.st = s;
    return r;
  endfunction

  task automatic push_fetch(input int t1_extra);
    out_t e;
    e = o(4'd1); e.pcout = 1; e.marin = 1; e.zin = 1; e.alu = 8'h20; sbq.push_back(e);
    e = o(4'd2); e.zlo = 1; e.pcin = 1; e.rd = 1; e.mdrin = 1; sbq.push_back(e);
    e.pcin = 0;
    for (int k = 0; k < t1_extra; k++) sbq.push_back(e);
    e = o(4'd3); e.mdrout = 1; e.irin = 1; sbq.push_back(e);
  endtask

  task automatic step(input logic mr, input logic rn, output out_t obs);
    @(posedge clock);
    #1;
    mem_ready = mr;
    run = rn;
    @(negedge clock);
    obs = dut_o;
  endtask

  task automatic do_reset();
    clear = 0; run = 0; mem_ready = 1; IR = '0;
    repeat (2) @(negedge clock);
    clear = 1;
    sbq.delete();
  endtask

  task automatic test_reset();
    out_t e, obs;
    clear = 0; run = 0; mem_ready = 1; IR = '0;
    #1;
    checks++;
    if (dut_o !== o(4'd0)) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_o, o(4'd0));
    end
    @(negedge clock); clear = 1;
    IR = {5'b00011, 4'd3, 4'd1, 4'd2, 15'd0};
    push_fetch(0);
    e = o(4'd4); e.rout = 16'h0002; e.yin = 1; sbq.push_back(e);
    e = o(4'd5); e.rout = 16'h0004; e.zin = 1; e.alu = 8'h03; sbq.push_back(e);
    run = 1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, obs);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_pre cycle %0d: got %h expected %h", i, obs, e); end
    end
    #2 clear = 0;
    #1;
    checks++;
    if (dut_o !== o(4'd0)) begin
      errors++; $display("FAIL reset_async: got %h expected %h", dut_o, o(4'd0));
    end
    #1 clear = 1;
    step(1'b1, 1'b1, obs);
    e = o(4'd1); e.pcout = 1; e.marin = 1; e.zin = 1; e.alu = 8'h20;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release_t0: got %h expected %h", obs, e); end
  endtask

  task automatic test_add();
    out_t e, obs;
    int n;
    do_reset();
    IR = {5'b00011, 4'd3, 4'd1, 4'd2, 15'd0};
    push_fetch(0);
    e = o(4'd4); e.rout = 16'h0002; e.yin = 1; sbq.push_back(e);
    e = o(4'd5); e.rout = 16'h0004; e.zin = 1; e.alu = 8'h03; sbq.push_back(e);
    e = o(4'd6); e.zlo = 1; e.rin = 16'h0008; e.dn = 1; sbq.push_back(e);
    n = sbq.size();
    run = 1;
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i < n - 1), obs);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL add cycle %0d: got %h expected %h", i, obs, e); end
    end
    step(1'b1, 1'b0, obs); checks++;
    if (obs !== o(4'd0)) begin errors++; $display("FAIL add_idle: got %h expected %h", obs, o(4'd0)); end
  endtask

  task automatic test_ld_wait();
    out_t e, obs;
    int n;
    do_reset();
    IR = {5'b00000, 4'd2, 4'd1, 19'd5};
    push_fetch(0);
    e = o(4'd4); e.rout = 16'h0002; e.yin = 1; sbq.push_back(e);
    e = o(4'd5); e.cout = 1; e.zin = 1; e.alu = 8'h03; sbq.push_back(e);
    e = o(4'd6); e.zlo = 1; e.marin = 1; sbq.push_back(e);
    e = o(4'd7); e.rd = 1; e.mdrin = 1;
    for (int k = 0; k < 4; k++) sbq.push_back(e);
    e = o(4'd8); e.mdrout = 1; e.rin = 16'h0004; e.dn = 1; sbq.push_back(e);
    n = sbq.size();
    run = 1;
    for (int i = 0; i < n; i++) begin
      step(!(i >= 6 && i <= 8), (i < n - 1), obs);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL ld cycle %0d: got %h expected %h", i, obs, e); end
    end
    checks++;
    if (n != 11) begin errors++; $display("FAIL ld_len: got %0d expected 11", n); end
  endtask

  task automatic test_mul();
    out_t e, obs;
    int n;
    do_reset();
    IR = {5'b01111, 4'd4, 4'd5, 19'd0};
    push_fetch(0);
    e = o(4'd4); e.rout = 16'h0010; e.yin = 1; sbq.push_back(e);
    e = o(4'd5); e.rout = 16'h0020; e.zin = 1; e.alu = 8'h0F; sbq.push_back(e);
    e = o(4'd6); e.zlo = 1; e.loin = 1; sbq.push_back(e);
    e = o(4'd7); e.zhi = 1; e.hiin = 1; e.dn = 1; sbq.push_back(e);
    n = sbq.size();
    run = 1;
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i < n - 1), obs);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mul cycle %0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_illegal();
    out_t e, obs;
    int n;
    do_reset();
    IR = {5'b10101, 27'd0};
    push_fetch(0);
    sbq.push_back(o(4'd4));
    e = o(4'd9); e.hl = 1; e.il = 1;
    for (int k = 0; k < 4; k++) sbq.push_back(e);
    n = sbq.size();
    run = 1;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, obs);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, e); end
    end
    #2 clear = 0;
    #1; checks++;
    if (dut_o !== o(4'd0)) begin errors++; $display("FAIL illegal_clear: got %h expected %h", dut_o, o(4'd0)); end
    clear = 1;
  endtask

  task automatic test_st_run_drop();
    out_t e, obs;
    int n;
    do_reset();
    IR = {5'b00010, 4'd3, 4'd1, 19'd2};
    push_fetch(0);
    e = o(4'd4); e.rout = 16'h0002; e.yin = 1; sbq.push_back(e);
    e = o(4'd5); e.cout = 1; e.zin = 1; e.alu = 8'h03; sbq.push_back(e);
    e = o(4'd6); e.zlo = 1; e.marin = 1; sbq.push_back(e);
    e = o(4'd7); e.rout = 16'h0008; e.mdrin = 1; sbq.push_back(e);
    e = o(4'd8); e.wr = 1;
    sbq.push_back(e); sbq.push_back(e);
    e.dn = 1; sbq.push_back(e);
    n = sbq.size();
    run = 1;
    for (int i = 0; i < n; i++) begin
      step(!(i == 7 || i == 8), (i < 3), obs);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL st cycle %0d: got %h expected %h", i, obs, e); end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, obs); checks++;
      if (obs !== o(4'd0)) begin errors++; $display("FAIL st_idle %0d: got %h expected %h", i, obs, o(4'd0)); end
    end
  endtask

  task automatic test_back_to_back();
    out_t e, obs;
    int n;
    do_reset();
    IR = {5'b11000, 27'd0};
    push_fetch(1);
    e = o(4'd4); e.dn = 1; sbq.push_back(e);
    push_fetch(0);
    sbq.push_back(e);
    n = sbq.size();
    run = 1;
    for (int i = 0; i < n; i++) begin
      step((i != 1), (i < n - 1), obs);
      e = sbq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b cycle %0d: got %h expected %h", i, obs, e); end
    end
    step(1'b1, 1'b0, obs); checks++;
    if (obs !== o(4'd0)) begin errors++; $display("FAIL b2b_idle: got %h expected %h", obs, o(4'd0)); end
  endtask

  initial begin
    clear = 0; run = 0; mem_ready = 1; IR = '0;
    test_reset();
    test_add();
    test_ld_wait();
    test_mul();
    test_illegal();
    test_st_run_drop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
